// File: rtl/rggen_local_bus_pkg.sv
// Shared types and helpers for the local-bus register decoder.
package rggen_local_bus_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'b001,
        ACCESS  = 3'b010,
        RESPOND = 3'b100
    } state_e;

    localparam logic [1:0] STATUS_OKAY   = 2'b00;
    localparam logic [1:0] STATUS_ERROR  = 2'b01;
    localparam logic [1:0] STATUS_EXOKAY = 2'b10;

    // Byte address to register word index for a bus of data_width bits.
    function automatic logic [31:0] word_index(input logic [31:0] address,
                                               input int unsigned data_width = 32);
        return address >> $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/rggen_local_bus_decoder.sv
// Local-bus command decoder: selects one register slot, waits for its ready,
// and returns data/status. Unaligned, unmapped and timed-out accesses get SLVERR.
module rggen_local_bus_decoder
    import rggen_local_bus_pkg::*;
#(
    parameter int DATA_WIDTH          = 32,
    parameter int LOCAL_ADDRESS_WIDTH = 16,
    parameter int REGISTERS           = 4,
    parameter int TIMEOUT_CYCLES      = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_command_valid,
    input  logic                            i_write,
    input  logic                            i_read,
    input  logic [LOCAL_ADDRESS_WIDTH-1:0]  i_address,
    input  logic [DATA_WIDTH/8-1:0]         i_strobe,
    input  logic [DATA_WIDTH-1:0]           i_write_data,
    input  logic [DATA_WIDTH-1:0]           i_write_mask,
    output logic                            o_response_ready,
    output logic [DATA_WIDTH-1:0]           o_read_data,
    output logic [1:0]                      o_status,
    output logic [REGISTERS-1:0]            o_reg_select,
    output logic                            o_reg_write,
    output logic                            o_reg_read,
    output logic [DATA_WIDTH-1:0]           o_reg_write_data,
    output logic [DATA_WIDTH-1:0]           o_reg_write_mask,
    input  logic [REGISTERS-1:0]            i_reg_ready,
    input  logic [REGISTERS*DATA_WIDTH-1:0] i_reg_read_data,
    input  logic [REGISTERS-1:0]            i_reg_error
);

    localparam int IDX_W = (REGISTERS > 1) ? $clog2(REGISTERS) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [31:0]      LOW_MASK    = 32'(DATA_WIDTH / 8 - 1);

    state_e                  state;
    logic [IDX_W-1:0]        index_q;
    logic [CNT_W-1:0]        count;
    logic [31:0]             addr_ext;
    logic [31:0]             index_full;
    logic                    hit;
    logic [REGISTERS-1:0]    select_next;
    logic [DATA_WIDTH-1:0]   slot_data;
    logic                    unused_strobe;

    // Slots are written through the bit mask, so the byte strobe has no consumer.
    assign unused_strobe = ^i_strobe;

    assign addr_ext    = 32'(i_address);
    assign index_full  = word_index(addr_ext, DATA_WIDTH);
    assign hit         = ((addr_ext & LOW_MASK) == '0) && (index_full < 32'(REGISTERS))
                         && (i_write || i_read);
    assign select_next = {{(REGISTERS-1){1'b0}}, 1'b1} << index_full;
    assign slot_data   = i_reg_read_data[index_q*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            index_q          <= '0;
            count            <= '0;
            o_response_ready <= 1'b0;
            o_read_data      <= '0;
            o_status         <= STATUS_OKAY;
            o_reg_select     <= '0;
            o_reg_write      <= 1'b0;
            o_reg_read       <= 1'b0;
            o_reg_write_data <= '0;
            o_reg_write_mask <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_command_valid) begin
                        if (hit) begin
                            state            <= ACCESS;
                            index_q          <= index_full[IDX_W-1:0];
                            o_reg_select     <= select_next;
                            o_reg_write      <= i_write;
                            o_reg_read       <= i_read;
                            o_reg_write_data <= i_write_data;
                            o_reg_write_mask <= i_write_mask;
                        end else begin
                            state            <= RESPOND;
                            o_response_ready <= 1'b1;
                            o_read_data      <= '0;
                            o_status         <= STATUS_ERROR;
                        end
                    end
                end
                ACCESS: begin
                    // Ready is checked first so a late ready still beats the timeout.
                    if (i_reg_ready[index_q]) begin
                        state            <= RESPOND;
                        o_response_ready <= 1'b1;
                        o_read_data      <= o_reg_read ? slot_data : '0;
                        o_status         <= {1'b0, i_reg_error[index_q]};
                        o_reg_select     <= '0;
                        o_reg_write      <= 1'b0;
                        o_reg_read       <= 1'b0;
                    end else if ((TIMEOUT_CYCLES != 0) && (count == TIMEOUT_VAL)) begin
                        state            <= RESPOND;
                        o_response_ready <= 1'b1;
                        o_read_data      <= '0;
                        o_status         <= STATUS_ERROR;
                        o_reg_select     <= '0;
                        o_reg_write      <= 1'b0;
                        o_reg_read       <= 1'b0;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        count <= count + 1'b1;
                    end
                end
                RESPOND: begin
                    state            <= IDLE;
                    count            <= '0;
                    o_response_ready <= 1'b0;
                    o_read_data      <= '0;
                    o_status         <= STATUS_OKAY;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (rst) $onehot0(o_reg_select));
    assert property (@(posedge clk) disable iff (rst) o_response_ready |=> !o_response_ready);

endmodule

// File: doc/rggen_local_bus_decoder.md
Name: rggen_local_bus_decoder

Overview:
- Sits directly downstream of the register-block host interface and consumes its local-bus command (command_valid / write / read / address / strobe / write_data / write_mask).
- Decodes the word address into one of REGISTERS register slots and forwards the access as a per-register select with its own ready handshake.
- Collects read data and error, then returns response_ready / read_data / status to the host interface.
- Generates SLVERR itself for unaligned, unmapped and timed-out accesses.

Parameters:
- DATA_WIDTH, 32: local data width in bits; power of two, minimum 8.
- LOCAL_ADDRESS_WIDTH, 16: byte-address width of the local bus.
- REGISTERS, 4: number of register slots. Slot i sits at byte address i*(DATA_WIDTH/8).
- TIMEOUT_CYCLES, 16: maximum number of ACCESS cycles before a forced SLVERR. Value 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- i_command_valid  in  1  command present; held high until the cycle after o_response_ready
- i_write  in  1  write command
- i_read  in  1  read command
- i_address  in  LOCAL_ADDRESS_WIDTH  byte address
- i_strobe  in  DATA_WIDTH/8  byte strobe
- i_write_data  in  DATA_WIDTH  write data
- i_write_mask  in  DATA_WIDTH  bit mask
- o_response_ready  out  1  one-cycle response pulse
- o_read_data  out  DATA_WIDTH  read data, valid while o_response_ready is high
- o_status  out  2  bit0 = error (becomes SLVERR upstream); bit1 = exclusive-okay, tied 0
- o_reg_select  out  REGISTERS  one-hot slot select
- o_reg_write  out  1  write qualifier to the slots
- o_reg_read  out  1  read qualifier to the slots
- o_reg_write_data  out  DATA_WIDTH  registered copy of i_write_data
- o_reg_write_mask  out  DATA_WIDTH  registered copy of i_write_mask
- i_reg_ready  in  REGISTERS  per-slot access done
- i_reg_read_data  in  REGISTERS*DATA_WIDTH  packed; slot i occupies [i*DATA_WIDTH +: DATA_WIDTH]
- i_reg_error  in  REGISTERS  per-slot error, sampled together with i_reg_ready

Behaviour:
- Reset: state IDLE; all outputs 0; timeout counter 0. Reset asserted mid-access aborts the access at once: selects drop, no response is issued.
- States (one-hot): IDLE, ACCESS, RESPOND.
- IDLE, i_command_valid low: stay in IDLE.
- IDLE, i_command_valid high: compute index = i_address >> log2(DATA_WIDTH/8) and latch the command fields.
  - Unaligned (low log2(DATA_WIDTH/8) address bits nonzero), index >= REGISTERS, or neither read nor write: go to RESPOND with status 2'b01 and read_data 0. No select is ever asserted.
  - Otherwise: go to ACCESS with o_reg_select = 1<<index, o_reg_write / o_reg_read and the write data/mask registers loaded.
- ACCESS:
  - Selected i_reg_ready high: capture the slot's read data (reads only; writes capture 0) and status = {1'b0, i_reg_error[index]}. Go to RESPOND; selects drop.
  - Else counter++. On reaching TIMEOUT_CYCLES: go to RESPOND with status 2'b01 and read_data 0.
  - Ready and timeout in the same cycle: ready wins.
  - i_reg_ready bits of unselected slots are ignored.
- RESPOND: o_response_ready = 1 for exactly one cycle with o_read_data / o_status valid. Next cycle: back to IDLE, with response ready, data, status and counter cleared. A command_valid still high in this cycle is not re-accepted.
- Latency from command_valid to response_ready:
  - error: 1 cycle
  - hit with immediate ready: 2 cycles
  - hit with N wait cycles: 2+N cycles
- Strobe is not forwarded; slots use the write mask.
- i_command_valid dropping during ACCESS is a protocol violation. It is ignored and the access completes normally.
- Assertions:
  - o_reg_select is one-hot or zero.
  - o_response_ready is never high on two consecutive cycles.

Decomposition:
- Package rggen_local_bus_pkg holds:
  - the state enum
  - status constants: STATUS_OKAY = 2'b00, STATUS_ERROR = 2'b01, STATUS_EXOKAY = 2'b10
  - function word_index(address)
- No sub-module. Decode, FSM and timeout counter form one module of roughly 180 lines.

Test Plan:
- Read slot 2 (DATA_WIDTH 32): address 0x0008; slot ready in its first ACCESS cycle with data 0xCAFE_0002 -> select 4'b0100 for one cycle; response_ready 2 cycles after command; read_data 0xCAFE_0002; status 00.
- Write slot 1: address 0x0004, write_data 0x1234_5678, mask 0x0000_FFFF; ready after 3 wait cycles -> o_reg_write_data / o_reg_write_mask stable throughout ACCESS; response at cycle 5; read_data 0; status 00.
- Unmapped and unaligned: read 0x0010 with REGISTERS 4, then write 0x0002 -> each gives response 1 cycle after command with status 01 and no select asserted.
- Timeout: TIMEOUT_CYCLES 16, slot 0 never ready -> response on cycle 18 with status 01 and read_data 0. A second run with ready arriving exactly on the 16th ACCESS cycle -> status 00 with the slot's data.
- Slot error: read slot 3 with ready=1 and error=1 -> status 01 and read_data passed through.
- Reset mid-access: assert rst during ACCESS -> selects and response low at once; after release, a read of slot 0 completes normally.
